// File: rtl/branch_history_table.sv
// Branch history table: 2**INDEX_WIDTH two-bit prediction counters indexed by
// PC xor global history. The counters are only stored here; the MEM stage
// computes the new counter value and writes it back. After reset an INIT
// sweep loads every entry with weakly-not-taken before predictions are valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping the table with 01, one entry per cycle; ready=0
// ST_RUN  | table valid; predictions, write-back and ghr updates live
module branch_history_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int GHR_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            if_pc,
  output logic [1:0]             if_predicted_branch_outcome,
  output logic                   if_predict_taken,
  output logic [INDEX_WIDTH-1:0] if_bht_index,
  output logic                   ready,
  input  logic                   mem_load_prediction,
  input  logic [INDEX_WIDTH-1:0] mem_bht_index,
  input  logic [1:0]             mem_updated_prediction,
  input  logic                   mem_actual_branch_outcome
);

  localparam int                     ENTRIES  = 1 << INDEX_WIDTH;
  localparam logic [0:0]             ST_INIT  = 1'b0;
  localparam logic [0:0]             ST_RUN   = 1'b1;
  localparam logic [1:0]             CNT_WN   = 2'b01;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0]   ghr_shift;
  logic [1:0]             table_q [ENTRIES];

  logic [INDEX_WIDTH-1:0] ghr_ext;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic                   run_en;
  logic                   upd_en;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic [1:0]             wr_val;
  logic                   unused_pc_bits;

  // Only the word-aligned index slice of the PC participates in the lookup.
  assign unused_pc_bits = ^{if_pc[31:INDEX_WIDTH+2], if_pc[1:0]};

  // Zero-extend the history to the index width.
  always_comb begin
    ghr_ext                  = '0;
    ghr_ext[GHR_WIDTH-1:0]   = ghr_q;
  end

  // Next history value: shift the resolved outcome in at the LSB.
  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign ghr_shift = mem_actual_branch_outcome;
    end else begin : g_ghr_multi
      assign ghr_shift = {ghr_q[GHR_WIDTH-2:0], mem_actual_branch_outcome};
    end
  endgenerate

  // Lookup index uses the registered history, so a same-cycle ghr update
  // only affects the following fetch.
  assign rd_index     = if_pc[INDEX_WIDTH+1:2] ^ ghr_ext;
  assign if_bht_index = rd_index;

  // Reset overrides RUN immediately so nothing leaks out or gets written
  // while rst is held.
  assign run_en = (state_q == ST_RUN) && !rst;
  assign upd_en = run_en && mem_load_prediction;
  assign ready  = run_en;

  // FSM and history next-state logic.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    case (state_q)
      ST_INIT: begin
        if (sweep_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (upd_en) begin
          ghr_d = ghr_shift;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Single table write port shared by the INIT sweep and MEM write-back.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        wr_en  = 1'b1;
        wr_idx = sweep_q;
        wr_val = CNT_WN;
      end else if (upd_en) begin
        wr_en  = 1'b1;
        wr_idx = mem_bht_index;
        wr_val = mem_updated_prediction;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Counter storage; contents are rebuilt by the INIT sweep, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[wr_idx] <= wr_val;
    end
  end

  // Prediction read with write-back bypass for a same-entry collision.
  always_comb begin
    if (!run_en) begin
      if_predicted_branch_outcome = CNT_WN;
    end else if (upd_en && (mem_bht_index == rd_index)) begin
      if_predicted_branch_outcome = mem_updated_prediction;
    end else begin
      if_predicted_branch_outcome = table_q[rd_index];
    end
  end

  assign if_predict_taken = if_predicted_branch_outcome[1];

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: a behavioural model of the table, history
// and warm-up period, compared against the DUT every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [1:0]  if_predicted_branch_outcome;
  logic        if_predict_taken;
  logic [5:0]  if_bht_index;
  logic        ready;
  logic        mem_load_prediction;
  logic [5:0]  mem_bht_index;
  logic [1:0]  mem_updated_prediction;
  logic        mem_actual_branch_outcome;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [1:0] m_tbl [64];
  logic [5:0] m_ghr;
  int         m_busy;

  always #5 clk = ~clk;

  branch_history_table #(.INDEX_WIDTH(6), .GHR_WIDTH(6)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .if_pc                      (if_pc),
    .if_predicted_branch_outcome(if_predicted_branch_outcome),
    .if_predict_taken           (if_predict_taken),
    .if_bht_index               (if_bht_index),
    .ready                      (ready),
    .mem_load_prediction        (mem_load_prediction),
    .mem_bht_index              (mem_bht_index),
    .mem_updated_prediction     (mem_updated_prediction),
    .mem_actual_branch_outcome  (mem_actual_branch_outcome)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: reset makes every entry weakly-not-taken and clears history; the
  // table then needs 64 warm-up cycles before it accepts updates.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
      m_ghr  = '0;
      m_busy = 64;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (mem_load_prediction) begin
      m_tbl[mem_bht_index] = mem_updated_prediction;
      m_ghr = {m_ghr[4:0], mem_actual_branch_outcome};
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      logic       e_ready;
      logic [5:0] e_idx;
      logic [1:0] e_pred;
      e_ready = !rst && (m_busy == 0);
      e_idx   = if_pc[7:2] ^ m_ghr;
      if (!e_ready)
        e_pred = 2'b01;
      else if (mem_load_prediction && mem_bht_index == e_idx)
        e_pred = mem_updated_prediction;
      else
        e_pred = m_tbl[e_idx];
      check("model_ready", int'(ready), int'(e_ready));
      check("model_index", int'(if_bht_index), int'(e_idx));
      check("model_pred", int'(if_predicted_branch_outcome), int'(e_pred));
      check("model_taken", int'(if_predict_taken), int'(e_pred[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    mem_load_prediction = 1'b0;
    mem_bht_index = '0;
    mem_updated_prediction = '0;
    mem_actual_branch_outcome = 1'b0;
    tick();
    chk_en = 1'b1;
    look();
    check("rst_ready", int'(ready), 0);
    check("rst_pred", int'(if_predicted_branch_outcome), 1);
    tick();
    rst = 1'b0;

    // warm-up: exactly 64 cycles of ready=0, then ready with all entries 01
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      look();
      check("init_ready", int'(ready), 0);
      check("init_pred", int'(if_predicted_branch_outcome), 1);
      check("init_index", int'(if_bht_index), i);
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      look();
      check("post_init_ready", int'(ready), 1);
      check("post_init_pred", int'(if_predicted_branch_outcome), 1);
      check("post_init_taken", int'(if_predict_taken), 0);
      tick();
    end

    // write 11 to index 5, read it back next cycle
    if_pc = 32'h0;
    mem_load_prediction = 1'b1;
    mem_bht_index = 6'd5;
    mem_updated_prediction = 2'b11;
    mem_actual_branch_outcome = 1'b0;
    tick();
    mem_load_prediction = 1'b0;
    if_pc = 32'h14;
    look();
    check("wr5_index", int'(if_bht_index), 5);
    check("wr5_pred", int'(if_predicted_branch_outcome), 3);
    check("wr5_taken", int'(if_predict_taken), 1);
    tick();

    // same-cycle bypass of 10 to index 9
    if_pc = 32'h24;
    mem_load_prediction = 1'b1;
    mem_bht_index = 6'd9;
    mem_updated_prediction = 2'b10;
    look();
    check("bypass_index", int'(if_bht_index), 9);
    check("bypass_pred", int'(if_predicted_branch_outcome), 2);
    check("bypass_taken", int'(if_predict_taken), 1);
    tick();
    mem_load_prediction = 1'b0;
    look();
    check("stored9_pred", int'(if_predicted_branch_outcome), 2);
    tick();

    // three taken outcomes -> history 000111
    for (int k = 0; k < 3; k++) begin
      mem_load_prediction = 1'b1;
      mem_bht_index = 6'(20 + k);
      mem_updated_prediction = 2'b00;
      mem_actual_branch_outcome = 1'b1;
      tick();
    end
    mem_load_prediction = 1'b0;
    if_pc = 32'h0;
    look();
    check("ghr7_index", int'(if_bht_index), 7);
    tick();
    if_pc = 32'h1C;
    look();
    check("ghr7_index_b", int'(if_bht_index), 0);
    tick();

    // write attempted during INIT is ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_load_prediction = (i == 10);
      mem_bht_index = 6'd3;
      mem_updated_prediction = 2'b11;
      mem_actual_branch_outcome = 1'b1;
      look();
      check("init2_ready", int'(ready), 0);
      tick();
    end
    mem_load_prediction = 1'b0;
    if_pc = 32'h0C;
    look();
    check("initwr_ready", int'(ready), 1);
    check("initwr_index", int'(if_bht_index), 3);
    check("initwr_pred", int'(if_predicted_branch_outcome), 1);
    tick();

    // randomized traffic, occasional resets in INIT or RUN
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if_pc = $urandom;
      mem_load_prediction = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        mem_bht_index = if_pc[7:2] ^ m_ghr;
      else
        mem_bht_index = 6'($urandom);
      mem_updated_prediction = 2'($urandom);
      mem_actual_branch_outcome = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    mem_load_prediction = 1'b0;
    for (int n = 0; n < 200 && !ready; n++) tick();
    look();
    check("wait_ready", int'(ready), 1);
    tick();

    // RUN writes, then reset mid-RUN reruns the sweep
    for (int k = 0; k < 4; k++) begin
      mem_load_prediction = 1'b1;
      mem_bht_index = 6'(k * 7);
      mem_updated_prediction = 2'b11;
      mem_actual_branch_outcome = 1'b1;
      tick();
    end
    mem_load_prediction = 1'b0;
    rst = 1'b1;
    look();
    check("midrun_rst_ready", int'(ready), 0);
    check("midrun_rst_pred", int'(if_predicted_branch_outcome), 1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      look();
      check("rerun_ready", int'(ready), 0);
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      look();
      check("rerun_index", int'(if_bht_index), i);
      check("rerun_pred", int'(if_predicted_branch_outcome), 1);
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
